// File: rtl/mapper_cfg.sv
// mapper_cfg: parses framed MCU commands, holds args/mapper_id and sequences mapper_rst.
// Build option MAPPER_CFG_CHECKSUM_EN adds a trailing XOR checksum byte to SET frames.
module mapper_cfg #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RST_HOLD       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] args,
  output logic [7:0]  mapper_id,
  output logic        mapper_rst,
  output logic        cfg_valid,
  output logic        err_pulse
);

  localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [7:0] OP_SET  = 8'h01;
  localparam logic [7:0] OP_GET  = 8'h02;
  localparam logic [7:0] OP_RSTM = 8'h03;
  localparam logic [7:0] ACK     = 8'h5A;
  localparam logic [7:0] NAK     = 8'hEE;

`ifdef MAPPER_CFG_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE = 3'd0, RX_ID = 3'd1, RX_ARG = 3'd2, RX_SUM = 3'd3, REPLY = 3'd4} state_t;
  logic [31:0] sh_args_r;
  logic [7:0]  sum_r;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, RX_ID = 3'd1, RX_ARG = 3'd2, REPLY = 3'd4} state_t;
  logic [23:0] sh_args_r;
`endif

  state_t            state_r;
  logic [1:0]        arg_idx_r;
  logic [7:0]        sh_id_r;
  logic [GAP_W-1:0]  gap_r;
  logic [HOLD_W-1:0] hold_r;
  logic [2:0]        reply_len_r;
  logic [2:0]        reply_idx_r;
  logic [31:0]       args_r;
  logic [7:0]        mapper_id_r;
  logic              cfg_valid_r;
  logic              err_pulse_r;
  logic              tx_valid_r;
  logic [7:0]        tx_data_r;
  logic              rx_ready_r;
  logic              mapper_rst_r;

  logic accept_s;
  logic in_rx_s;
  logic timeout_s;
  logic commit_s;
  logic rstm_s;
  logic hold_load_s;

  function automatic logic [7:0] reply_byte(input logic [2:0] idx, input logic [7:0] id,
                                            input logic [31:0] a);
    case (idx)
      3'd0:    reply_byte = id;
      3'd1:    reply_byte = a[7:0];
      3'd2:    reply_byte = a[15:8];
      3'd3:    reply_byte = a[23:16];
      3'd4:    reply_byte = a[31:24];
      default: reply_byte = 8'h00;
    endcase
  endfunction

  // Byte acceptance, timeout detection and the commit/RSTM events that load the hold counter.
  always_comb begin
    accept_s  = rx_valid && rx_ready_r;
    in_rx_s   = (state_r != IDLE) && (state_r != REPLY);
    timeout_s = in_rx_s && (gap_r == GAP_W'(TIMEOUT_CYCLES));
    commit_s  = 1'b0;
    rstm_s    = 1'b0;
    if (accept_s && !timeout_s) begin
      case (state_r)
        IDLE:    rstm_s = (rx_data == OP_RSTM);
`ifdef MAPPER_CFG_CHECKSUM_EN
        RX_SUM:  commit_s = (rx_data == sum_r);
`else
        RX_ARG:  commit_s = (arg_idx_r == 2'd3);
`endif
        default: commit_s = 1'b0;
      endcase
    end else begin
      commit_s = 1'b0;
    end
    hold_load_s = commit_s || rstm_s;
  end

  // Frame parser FSM with registered reply channel and committed configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      arg_idx_r   <= 2'd0;
      sh_id_r     <= 8'h00;
      sh_args_r   <= '0;
`ifdef MAPPER_CFG_CHECKSUM_EN
      sum_r       <= 8'h00;
`endif
      gap_r       <= {GAP_W{1'b0}};
      reply_len_r <= 3'd0;
      reply_idx_r <= 3'd0;
      args_r      <= 32'h0000_0000;
      mapper_id_r <= 8'h00;
      cfg_valid_r <= 1'b0;
      err_pulse_r <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      rx_ready_r  <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      if (accept_s) begin
        gap_r <= {GAP_W{1'b0}};
      end else if (in_rx_s) begin
        gap_r <= gap_r + GAP_W'(1);
      end else begin
        gap_r <= {GAP_W{1'b0}};
      end

      if (timeout_s) begin
        // Abort silently: frame discarded, receiver stays open.
        state_r     <= IDLE;
        err_pulse_r <= 1'b1;
        rx_ready_r  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            rx_ready_r <= 1'b1;
            if (accept_s) begin
              case (rx_data)
                OP_SET: begin
                  state_r <= RX_ID;
`ifdef MAPPER_CFG_CHECKSUM_EN
                  sum_r   <= rx_data;
`endif
                end
                OP_GET: begin
                  state_r     <= REPLY;
                  rx_ready_r  <= 1'b0;
                  tx_valid_r  <= 1'b1;
                  tx_data_r   <= reply_byte(3'd0, mapper_id_r, args_r);
                  reply_len_r <= 3'd5;
                  reply_idx_r <= 3'd0;
                end
                OP_RSTM: begin
                  state_r     <= REPLY;
                  rx_ready_r  <= 1'b0;
                  tx_valid_r  <= 1'b1;
                  tx_data_r   <= ACK;
                  reply_len_r <= 3'd1;
                  reply_idx_r <= 3'd0;
                end
                default: begin
                  state_r     <= REPLY;
                  rx_ready_r  <= 1'b0;
                  tx_valid_r  <= 1'b1;
                  tx_data_r   <= NAK;
                  reply_len_r <= 3'd1;
                  reply_idx_r <= 3'd0;
                  err_pulse_r <= 1'b1;
                end
              endcase
            end
          end
          RX_ID: begin
            if (accept_s) begin
              sh_id_r   <= rx_data;
              arg_idx_r <= 2'd0;
              state_r   <= RX_ARG;
`ifdef MAPPER_CFG_CHECKSUM_EN
              sum_r     <= sum_r ^ rx_data;
`endif
            end
          end
          RX_ARG: begin
            if (accept_s) begin
              arg_idx_r <= arg_idx_r + 2'd1;
`ifdef MAPPER_CFG_CHECKSUM_EN
              sum_r     <= sum_r ^ rx_data;
`endif
              case (arg_idx_r)
                2'd0: sh_args_r[7:0]   <= rx_data;
                2'd1: sh_args_r[15:8]  <= rx_data;
                2'd2: sh_args_r[23:16] <= rx_data;
                default: begin
`ifdef MAPPER_CFG_CHECKSUM_EN
                  sh_args_r[31:24] <= rx_data;
                  state_r          <= RX_SUM;
`else
                  state_r <= RX_ARG;
`endif
                end
              endcase
            end
          end
`ifdef MAPPER_CFG_CHECKSUM_EN
          RX_SUM: begin
            if (accept_s && (rx_data != sum_r)) begin
              state_r     <= REPLY;
              rx_ready_r  <= 1'b0;
              tx_valid_r  <= 1'b1;
              tx_data_r   <= NAK;
              reply_len_r <= 3'd1;
              reply_idx_r <= 3'd0;
              err_pulse_r <= 1'b1;
            end
          end
`endif
          REPLY: begin
            if (tx_ready) begin
              if (reply_idx_r == (reply_len_r - 3'd1)) begin
                state_r    <= IDLE;
                tx_valid_r <= 1'b0;
                rx_ready_r <= 1'b1;
              end else begin
                reply_idx_r <= reply_idx_r + 3'd1;
                tx_data_r   <= reply_byte(reply_idx_r + 3'd1, mapper_id_r, args_r);
              end
            end
          end
          default: begin
            state_r    <= IDLE;
            rx_ready_r <= 1'b1;
          end
        endcase

        // Commit publishes the staged frame atomically and acknowledges it.
        if (commit_s) begin
`ifdef MAPPER_CFG_CHECKSUM_EN
          args_r <= sh_args_r;
`else
          args_r <= {rx_data, sh_args_r};
`endif
          mapper_id_r <= sh_id_r;
          cfg_valid_r <= 1'b1;
          state_r     <= REPLY;
          rx_ready_r  <= 1'b0;
          tx_valid_r  <= 1'b1;
          tx_data_r   <= ACK;
          reply_len_r <= 3'd1;
          reply_idx_r <= 3'd0;
        end
      end
    end
  end

  // Mapper reset hold: reloads on every commit/RSTM; stays asserted until a config exists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r       <= {HOLD_W{1'b0}};
      mapper_rst_r <= 1'b1;
    end else if (hold_load_s) begin
      hold_r       <= HOLD_W'(RST_HOLD);
      mapper_rst_r <= 1'b1;
    end else if (hold_r != {HOLD_W{1'b0}}) begin
      hold_r       <= hold_r - HOLD_W'(1);
      mapper_rst_r <= (hold_r != HOLD_W'(1)) || !cfg_valid_r;
    end else begin
      hold_r       <= hold_r;
      mapper_rst_r <= mapper_rst_r;
    end
  end

  assign rx_ready   = rx_ready_r;
  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign args       = args_r;
  assign mapper_id  = mapper_id_r;
  assign mapper_rst = mapper_rst_r;
  assign cfg_valid  = cfg_valid_r;
  assign err_pulse  = err_pulse_r;

endmodule

// File: tb/tb_mapper_cfg.sv
// Directed self-checking bench for mapper_cfg (covers the MAPPER_CFG_CHECKSUM_EN build too).
module tb_mapper_cfg;

  localparam int TMO  = 64;
  localparam int HOLD = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] args;
  logic [7:0]  mapper_id;
  logic        mapper_rst;
  logic        cfg_valid;
  logic        err_pulse;

  int n_checks = 0;
  int n_errors = 0;

  mapper_cfg #(.TIMEOUT_CYCLES(TMO), .RST_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .args(args), .mapper_id(mapper_id), .mapper_rst(mapper_rst),
    .cfg_valid(cfg_valid), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && w < 50) begin
      step();
      w++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_set(input logic [7:0] id, input logic [31:0] a);
    send_byte(8'h01);
    send_byte(id);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(a[23:16]);
    send_byte(a[31:24]);
`ifdef MAPPER_CFG_CHECKSUM_EN
    send_byte(8'h01 ^ id ^ a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]);
`endif
  endtask

  function automatic logic [7:0] get_exp(input int k);
    case (k)
      0:       return 8'h07;
      1:       return 8'h78;
      2:       return 8'h56;
      3:       return 8'h34;
      4:       return 8'h12;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int k;
    int cyc;
    int err_at;
    int err_cnt;
    int tx_seen;
    logic fire;

    clk = 1'b0; reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    step(); step(); step();
    check("rst_args", args, 32'h0);
    check("rst_id", 32'(mapper_id), 32'h0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_err", 32'(err_pulse), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mapper_rst", 32'(mapper_rst), 32'd1);
    reset = 1'b0;
    step(); step(); step();
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
    check("pre_set_mapper_rst", 32'(mapper_rst), 32'd1);

    // SET 07 / 0x12345678; args must not move mid-frame
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    check("midframe_args", args, 32'h0);
    check("midframe_cfg_valid", 32'(cfg_valid), 32'd0);
`ifdef MAPPER_CFG_CHECKSUM_EN
    send_byte(8'h12);
    send_byte(8'h0E);
`else
    send_byte(8'h12);
`endif
    check("set1_args", args, 32'h1234_5678);
    check("set1_id", 32'(mapper_id), 32'h07);
    check("set1_cfg_valid", 32'(cfg_valid), 32'd1);
    check("set1_tx_valid", 32'(tx_valid), 32'd1);
    check("set1_tx_data", 32'(tx_data), 32'h5A);
    check("set1_rx_ready", 32'(rx_ready), 32'd0);
    tx_ready = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (mapper_rst) hi++;
      step();
    end
    check("set1_hold_cycles", 32'(hi), 32'd16);
    check("set1_rst_low", 32'(mapper_rst), 32'd0);
    check("set1_tx_done", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // GET with tx_ready toggling
    send_byte(8'h02);
    k = 0; cyc = 0;
    while (k < 5 && cyc < 40) begin
      check("get_rx_ready", 32'(rx_ready), 32'd0);
      check("get_tx_valid", 32'(tx_valid), 32'd1);
      check("get_byte", 32'(tx_data), 32'(get_exp(k)));
      fire = cyc[0];
      tx_ready = fire;
      step();
      if (fire) k++;
      cyc++;
    end
    tx_ready = 1'b0;
    check("get_count", 32'(k), 32'd5);
    check("get_rx_ready_back", 32'(rx_ready), 32'd1);
    check("get_tx_valid_off", 32'(tx_valid), 32'd0);

    // bad opcode
    send_byte(8'h55);
    check("nak_tx_valid", 32'(tx_valid), 32'd1);
    check("nak_tx_data", 32'(tx_data), 32'hEE);
    check("nak_err", 32'(err_pulse), 32'd1);
    step();
    check("nak_err_one_cycle", 32'(err_pulse), 32'd0);
    check("nak_tx_data_hold", 32'(tx_data), 32'hEE);
    check("nak_args", args, 32'h1234_5678);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    check("nak_done", 32'(tx_valid), 32'd0);

    // timeout after 3 bytes
    send_byte(8'h01); send_byte(8'h09); send_byte(8'hEF);
    err_at = -1; err_cnt = 0; tx_seen = 0;
    for (int i = 1; i <= TMO + 5; i++) begin
      step();
      if (err_pulse) begin
        err_cnt++;
        if (err_at < 0) err_at = i;
      end
      if (tx_valid) tx_seen++;
    end
    check("tmo_err_cycle", 32'(err_at), 32'(TMO + 1));
    check("tmo_err_count", 32'(err_cnt), 32'd1);
    check("tmo_no_reply", 32'(tx_seen), 32'd0);
    check("tmo_args", args, 32'h1234_5678);
    check("tmo_rx_ready", 32'(rx_ready), 32'd1);

    send_set(8'h09, 32'hDEAD_BEEF);
    check("set2_args", args, 32'hDEAD_BEEF);
    check("set2_id", 32'(mapper_id), 32'h09);
    check("set2_tx_data", 32'(tx_data), 32'h5A);
    check("set2_mapper_rst", 32'(mapper_rst), 32'd1);

    // RSTM issued into the SET hold reloads the full hold
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    step(); step(); step();
    send_byte(8'h03);
    check("rstm_tx_data", 32'(tx_data), 32'h5A);
    check("rstm_tx_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (mapper_rst) hi++;
      step();
    end
    tx_ready = 1'b0;
    check("rstm_hold_cycles", 32'(hi), 32'd16);
    check("rstm_args", args, 32'hDEAD_BEEF);

`ifdef MAPPER_CFG_CHECKSUM_EN
    // frame 01 07 78 56 34 35 has checksum 0x29
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h78); send_byte(8'h56);
    send_byte(8'h34); send_byte(8'h35); send_byte(8'h00);
    check("sum_bad_tx_data", 32'(tx_data), 32'hEE);
    check("sum_bad_err", 32'(err_pulse), 32'd1);
    check("sum_bad_args", args, 32'hDEAD_BEEF);
    check("sum_bad_mapper_rst", 32'(mapper_rst), 32'd0);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h78); send_byte(8'h56);
    send_byte(8'h34); send_byte(8'h35); send_byte(8'h29);
    check("sum_ok_tx_data", 32'(tx_data), 32'h5A);
    check("sum_ok_args", args, 32'h3534_5678);
    check("sum_ok_id", 32'(mapper_id), 32'h07);
    check("sum_ok_mapper_rst", 32'(mapper_rst), 32'd1);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
`endif

    // reset in the middle of a frame
    send_byte(8'h01); send_byte(8'h05);
    reset = 1'b1;
    #1;
    check("midrst_args", args, 32'h0);
    check("midrst_id", 32'(mapper_id), 32'h0);
    check("midrst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("midrst_mapper_rst", 32'(mapper_rst), 32'd1);
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    step();
    reset = 1'b0;
    step(); step();
    check("postrst_rx_ready", 32'(rx_ready), 32'd1);
    check("postrst_tx_valid", 32'(tx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
